// File: rtl/isa_pkg.sv
// isa_pkg: opcode field layout, opcode values and fetch defaults shared by the front end.
package isa_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam logic [3:0] ADD = 4'd1, SUB = 4'd2, AND = 4'd3, OR = 4'd4, XOR = 4'd5;
  localparam logic [3:0] SLL = 4'd6, LOAD = 4'd7, STORE = 4'd8, ADDI = 4'd9, BEQ = 4'd10;
  localparam logic [3:0] BNE = 4'd11, UBRANCH = 4'd12, SRL = 4'd13, BLT = 4'd14, BGT = 4'd15;
  typedef logic [OPCODE_MSB-OPCODE_LSB:0] opcode_t;
  function automatic opcode_t opcode_of(logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH-entry queue with clear and occupancy count; head is read from register storage.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !clear) mem[wr_ptr] <= push_data;
  assign head = count != '0 ? mem[rd_ptr] : '0;
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: in-order instruction fetch with credit-limited requests, a response queue
// and branch flush that discards every response still in flight.
module fetch_queue_unit import isa_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            stall,
  input  logic            is_branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_opcode
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);
  logic [XLEN-1:0] fetch_pc, resp_pc, target;
  logic [CW-1:0] count, outstanding, discard;
  logic [2*XLEN-1:0] head;
  logic fire, take, push, pop;
  assign target = {branch_target[XLEN-1:2], 2'b00};
  // queued plus outstanding never exceeds DEPTH, so the queue cannot overflow
  assign imem_req_valid = !reset && !is_branch_taken && ({1'b0, count} + {1'b0, outstanding} < CAP);
  assign imem_req_addr = fetch_pc;
  assign fire = imem_req_valid && imem_req_ready;
  assign take = imem_resp_valid && outstanding != '0;
  assign push = take && discard == '0 && !is_branch_taken;
  assign out_valid = count != '0;
  assign pop = out_valid && !stall && !is_branch_taken;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(take);
      if (is_branch_taken) begin
        fetch_pc <= target;
        resp_pc <= target;
        discard <= outstanding - CW'(take);
      end else begin
        if (fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (push) resp_pc <= resp_pc + XLEN'(4);
        if (take && discard != '0) discard <= discard - 1'b1;
      end
    end
  sync_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .push_data({resp_pc, imem_resp_data}),
    .pop(pop),
    .clear(is_branch_taken),
    .count(count),
    .head(head)
  );
  assign out_pc = head[2*XLEN-1:XLEN];
  assign out_instr = head[XLEN-1:0];
  assign out_opcode = opcode_of(out_instr[31:0]);
endmodule
